// File: rtl/radiant_ext_trig_pkg.sv
// radiant_ext_trig_pkg: shared state encoding, frame constants and counter helpers
// for the RADIANT external trigger transmitter.
package radiant_ext_trig_pkg;
    localparam int CNT_W = 16;
    localparam int FRAME_BITS = 18;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PULSE   = 3'd1,
        S_GAP     = 3'd2,
        S_FRAME   = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/radiant_ext_trig_ser.sv
// radiant_ext_trig_ser: 18-bit event-number frame serializer, MSB first, each bit
// held BIT_CYCLES clocks. o_bit is the value the line must carry on the next cycle.
module radiant_ext_trig_ser
    import radiant_ext_trig_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_bit
);
    localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [FRAME_BITS-1:0] r_sh;
    logic [BW-1:0]         r_bcnt;
    logic [4:0]            r_nbits;
    logic                  r_busy;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sh    <= '0;
            r_bcnt  <= '0;
            r_nbits <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_sh    <= {START_BIT, i_data, STOP_BIT};
            r_bcnt  <= BW'(BIT_CYCLES - 1);
            r_nbits <= 5'(FRAME_BITS - 1);
            r_busy  <= 1'b1;
        end else if (i_abort) begin
            r_busy  <= 1'b0;
        end else if (r_busy) begin
            if (r_bcnt != '0) begin
                r_bcnt <= r_bcnt - 1'b1;
            end else if (r_nbits == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_sh    <= {r_sh[FRAME_BITS-2:0], 1'b0};
                r_nbits <= r_nbits - 1'b1;
                r_bcnt  <= BW'(BIT_CYCLES - 1);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && r_bcnt == '0 && r_nbits == '0;
    // Look one bit ahead so the registered line output stays aligned with the frame state
    assign o_bit  = i_start ? START_BIT : ((r_bcnt == '0) ? r_sh[FRAME_BITS-2] : r_sh[FRAME_BITS-1]);
endmodule

// File: rtl/radiant_ext_trig_tx.sv
// radiant_ext_trig_tx: TRIGOUT pulse generator with holdoff and sent/drop counters.
// Define RADIANT_EXT_TRIG_TX_INFO_EN to append a serial event-number frame after each pulse.
module radiant_ext_trig_tx
    import radiant_ext_trig_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        trig_i,
    input  logic [15:0] event_num_i,
    input  logic [7:0]  width_i,
    input  logic [15:0] holdoff_i,
    input  logic        invert_i,
    input  logic        cnt_clr_i,
    output logic        ext_trig_o,
    output logic        busy_o,
    output logic [15:0] sent_cnt_o,
    output logic [15:0] drop_cnt_o
);
    state_t           r_state, w_nxt, w_hold_nxt;
    logic [CNT_W-1:0] r_cnt, r_sent, r_drop;
    logic             r_line, w_active, w_accept, w_drop, w_last;

    assign w_accept   = trig_i && en_i && r_state == S_IDLE;
    assign w_drop     = trig_i && en_i && r_state != S_IDLE;
    assign w_last     = r_cnt == CNT_W'(1);
    assign w_hold_nxt = (holdoff_i == '0) ? S_IDLE : S_HOLDOFF;

`ifdef RADIANT_EXT_TRIG_TX_INFO_EN
    logic [15:0] r_event;
    logic        w_ser_start, w_ser_busy, w_ser_done, w_ser_bit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)      r_event <= '0;
        else if (!en_i)    r_event <= '0;
        else if (w_accept) r_event <= event_num_i;
    end

    assign w_ser_start = r_state == S_GAP && w_nxt == S_FRAME;

    radiant_ext_trig_ser #(.BIT_CYCLES(BIT_CYCLES)) u_ser (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_start (w_ser_start),
        .i_abort (!en_i),
        .i_data  (r_event),
        .o_busy  (w_ser_busy),
        .o_done  (w_ser_done),
        .o_bit   (w_ser_bit)
    );
`else
    logic w_unused;
    assign w_unused = ^{event_num_i, BIT_CYCLES[0], GAP_CYCLES[0]};
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (!en_i) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_nxt = trig_i ? S_PULSE : S_IDLE;
`ifdef RADIANT_EXT_TRIG_TX_INFO_EN
                S_PULSE:   w_nxt = w_last ? S_GAP : S_PULSE;
                S_GAP:     w_nxt = w_last ? S_FRAME : S_GAP;
                S_FRAME:   w_nxt = (w_ser_done || !w_ser_busy) ? w_hold_nxt : S_FRAME;
`else
                S_PULSE:   w_nxt = w_last ? w_hold_nxt : S_PULSE;
`endif
                S_HOLDOFF: w_nxt = w_last ? S_IDLE : S_HOLDOFF;
                default:   w_nxt = S_IDLE;
            endcase
        end
    end

    // Line D input is derived from the next state so the registered output tracks the state
    always_comb begin
`ifdef RADIANT_EXT_TRIG_TX_INFO_EN
        w_active = w_nxt == S_PULSE || (w_nxt == S_FRAME && w_ser_bit);
`else
        w_active = w_nxt == S_PULSE;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= (width_i == '0) ? CNT_W'(1) : CNT_W'(width_i);
        else if (w_nxt == S_HOLDOFF && r_state != S_HOLDOFF)
            r_cnt <= holdoff_i;
`ifdef RADIANT_EXT_TRIG_TX_INFO_EN
        else if (w_nxt == S_GAP && r_state != S_GAP)
            r_cnt <= CNT_W'(GAP_CYCLES);
`endif
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_line <= 1'b0;
            r_sent <= '0;
            r_drop <= '0;
        end else begin
            r_line <= w_active ^ invert_i;
            r_sent <= cnt_clr_i ? '0 : (w_accept ? sat_inc(r_sent) : r_sent);
            r_drop <= cnt_clr_i ? '0 : (w_drop ? sat_inc(r_drop) : r_drop);
        end
    end

    assign ext_trig_o = r_line;
    assign busy_o     = r_state != S_IDLE;
    assign sent_cnt_o = r_sent;
    assign drop_cnt_o = r_drop;
endmodule

// File: tb/tb_radiant_ext_trig_tx.sv
// tb_radiant_ext_trig_tx: directed-vector bench for radiant_ext_trig_tx; frame checks
// are included when RADIANT_EXT_TRIG_TX_INFO_EN is defined.
module tb_radiant_ext_trig_tx;
`ifdef RADIANT_EXT_TRIG_TX_INFO_EN
    localparam int FX = 4 + 18 * 2;
`else
    localparam int FX = 0;
`endif

    logic        clk_i, rst_n_i, en_i, trig_i, invert_i, cnt_clr_i;
    logic [15:0] event_num_i, holdoff_i;
    logic [7:0]  width_i;
    logic        ext_trig_o, busy_o;
    logic [15:0] sent_cnt_o, drop_cnt_o;
    int          n_vec = 0;
    int          n_err = 0;

    radiant_ext_trig_tx #(.BIT_CYCLES(2), .GAP_CYCLES(4)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .trig_i      (trig_i),
        .event_num_i (event_num_i),
        .width_i     (width_i),
        .holdoff_i   (holdoff_i),
        .invert_i    (invert_i),
        .cnt_clr_i   (cnt_clr_i),
        .ext_trig_o  (ext_trig_o),
        .busy_o      (busy_o),
        .sent_cnt_o  (sent_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Pulse trig_i for one cycle; edge e after acceptance is checked against width w and busy length bl
    task automatic fire(input string tag, input int w, input int bl, input int n, input logic [7:0] nw);
        trig_i = 1'b1;
        for (int e = 1; e <= n; e++) begin
            step();
            trig_i = 1'b0;
            if (e == 1) width_i = nw;
            if (e <= w + 1) check($sformatf("%s_line%0d", tag, e), ext_trig_o, ((e <= w) ? 1'b1 : 1'b0) ^ invert_i);
            check($sformatf("%s_busy%0d", tag, e), busy_o, (e <= bl) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        rst_n_i = 1'b0; en_i = 1'b1; trig_i = 1'b0; invert_i = 1'b1; cnt_clr_i = 1'b0;
        event_num_i = 16'h0; width_i = 8'd5; holdoff_i = 16'd10;
        #12;
        check("rst_line", ext_trig_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_sent", sent_cnt_o, 16'd0);
        check("rst_drop", drop_cnt_o, 16'd0);
        @(posedge clk_i); #2 rst_n_i = 1'b1;
        step();
        check("rel_line", ext_trig_o, 1'b1);
        invert_i = 1'b0;
        step();
        check("idle_line", ext_trig_o, 1'b0);

        fire("basic", 5, 15 + FX, 16 + FX, 8'd5);
        check("basic_sent", sent_cnt_o, 16'd1);
        check("basic_drop", drop_cnt_o, 16'd0);

        width_i = 8'd4; holdoff_i = 16'd2;
        fire("wchg", 4, 6 + FX, 7 + FX, 8'd9);
        check("wchg_sent", sent_cnt_o, 16'd2);

        cnt_clr_i = 1'b1; step(); cnt_clr_i = 1'b0;
        check("clr_sent", sent_cnt_o, 16'd0);
        check("clr_drop", drop_cnt_o, 16'd0);

        width_i = 8'd3; holdoff_i = 16'd4;
        trig_i = 1'b1;
        repeat (4) step();
        trig_i = 1'b0;
        check("b2b_sent", sent_cnt_o, 16'd1);
        check("b2b_drop", drop_cnt_o, 16'd3);
        repeat (60) step();
        check("b2b_idle", busy_o, 1'b0);

        width_i = 8'd255; holdoff_i = 16'hFFFF;
        trig_i = 1'b1;
        repeat (65537) step();
        check("sat_drop", drop_cnt_o, 16'hFFFF);
        check("sat_sent", sent_cnt_o, 16'd2);
        check("sat_busy", busy_o, 1'b1);
        cnt_clr_i = 1'b1; step(); cnt_clr_i = 1'b0; trig_i = 1'b0;
        check("clrpri_drop", drop_cnt_o, 16'd0);
        check("clrpri_sent", sent_cnt_o, 16'd0);
        en_i = 1'b0; step();
        check("dis_busy", busy_o, 1'b0);
        check("dis_line", ext_trig_o, 1'b0);
        en_i = 1'b1; step();

        width_i = 8'd0; holdoff_i = 16'd0;
        fire("w0", 1, 1 + FX, 2 + FX, 8'd0);
        fire("h0", 1, 1 + FX, 2 + FX, 8'd0);
        check("h0_sent", sent_cnt_o, 16'd2);

        width_i = 8'd2; holdoff_i = 16'd3; invert_i = 1'b1;
        step(); step();
        check("inv_idle", ext_trig_o, 1'b1);
        fire("inv", 2, 5 + FX, 6 + FX, 8'd2);
        invert_i = 1'b0;
        step();

        cnt_clr_i = 1'b1; step(); cnt_clr_i = 1'b0;
        width_i = 8'd20; holdoff_i = 16'd5;
        trig_i = 1'b1; step(); trig_i = 1'b0;
        check("abt_line1", ext_trig_o, 1'b1);
        step();
        check("abt_line2", ext_trig_o, 1'b1);
        en_i = 1'b0; step();
        check("abt_line", ext_trig_o, 1'b0);
        check("abt_busy", busy_o, 1'b0);
        trig_i = 1'b1; step(); trig_i = 1'b0;
        check("abt_sent", sent_cnt_o, 16'd1);
        check("abt_drop", drop_cnt_o, 16'd0);
        check("abt_idle", busy_o, 1'b0);
        en_i = 1'b1; step();

`ifdef RADIANT_EXT_TRIG_TX_INFO_EN
        begin
            logic [17:0] fr;
            logic        exp_l;
            fr = {1'b1, 16'hA5C3, 1'b0};
            width_i = 8'd3; holdoff_i = 16'd2; event_num_i = 16'hA5C3;
            trig_i = 1'b1;
            for (int e = 1; e <= 47; e++) begin
                step();
                trig_i = 1'b0;
                event_num_i = 16'h1234;
                exp_l = (e <= 3) ? 1'b1 : (e >= 8 && e <= 43) ? fr[17 - (e - 8) / 2] : 1'b0;
                check($sformatf("frm_line%0d", e), ext_trig_o, exp_l);
                check($sformatf("frm_busy%0d", e), busy_o, (e <= 45) ? 1'b1 : 1'b0);
            end
        end
`endif

        cnt_clr_i = 1'b1; step(); cnt_clr_i = 1'b0;
        invert_i = 1'b1; width_i = 8'd3; holdoff_i = 16'd40;
        step();
        trig_i = 1'b1; step(); trig_i = 1'b0;
        repeat (14) step();
        check("pre_rst_busy", busy_o, 1'b1);
        rst_n_i = 1'b0;
        #1;
        check("arst_line", ext_trig_o, 1'b0);
        check("arst_busy", busy_o, 1'b0);
        check("arst_sent", sent_cnt_o, 16'd0);
        check("arst_drop", drop_cnt_o, 16'd0);
        #2 rst_n_i = 1'b1;
        step();
        check("arel_line", ext_trig_o, 1'b1);
        invert_i = 1'b0;
        step();
        fire("post", 3, 43 + FX, 5, 8'd3);
        check("post_sent", sent_cnt_o, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
